cpu_result_checker: RTL and testbench

Synthesizable self-checking monitor attached to the single-cycle CPU's PC and register-file write port. Once started, it counts cycles, detects program halt (PC parked in a jump-to-self loop) or timeout, then compares up to NUM_CHECKS architectural registers against expected values. It reports per-check pass/fail, so one bench can grade fib, hanoi and simple programs without hierarchical peeking into the register file.

---
 rtl/cpu_result_checker_pkg.sv | 21 ++
 rtl/cpu_check_channel.sv | 56 +++++
 rtl/cpu_result_checker.sv | 157 +++++++++++++++
 tb/tb_cpu_result_checker.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_result_checker_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_result_checker_pkg                                                      |
// | State encoding and register-file constants shared by the checker and cpu.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package cpu_result_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int REG_ZERO  = 0;
  localparam int RF_ADDR_W = 5;

endpackage
`default_nettype wire

// File: rtl/cpu_check_channel.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_check_channel                                                           |
// | One check channel: shadows a single architectural register, flags mismatch.|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module cpu_check_channel
  import cpu_result_checker_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              cfg_valid,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              capture,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  output logic              mismatch
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_exp;
  logic [DATA_W-1:0] r_shadow;
  logic              w_hit;

  // r0 is hardwired to zero in the CPU, so its shadow must never move.
  assign w_hit = capture && rf_we && (rf_waddr == r_addr) &&
                 (rf_waddr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_addr   <= '0;
      r_exp    <= '0;
      r_shadow <= '0;
    end else if (load) begin
      r_valid  <= cfg_valid;
      r_addr   <= cfg_addr;
      r_exp    <= cfg_data;
      r_shadow <= '0;
    end else if (w_hit) begin
      r_shadow <= rf_wdata;
    end
  end

  assign mismatch = r_valid && (r_shadow != r_exp);

endmodule
`default_nettype wire

// File: rtl/cpu_result_checker.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_result_checker                                                          |
// | Watches PC and RF write port, detects halt/timeout, grades final registers.|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module cpu_result_checker
  import cpu_result_checker_pkg::*;
#(
  parameter int NUM_CHECKS  = 4,
  parameter int ADDR_W      = RF_ADDR_W,
  parameter int DATA_W      = 32,
  parameter int CYC_W       = 16,
  parameter int HALT_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CYC_W-1:0]             max_cycles,
  input  logic [DATA_W-1:0]            pc,
  input  logic                         rf_we,
  input  logic [ADDR_W-1:0]            rf_waddr,
  input  logic [DATA_W-1:0]            rf_wdata,
  input  logic [NUM_CHECKS-1:0]        exp_valid,
  input  logic [NUM_CHECKS*ADDR_W-1:0] exp_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
  output logic                         busy,
  output logic                         done,
  output logic                         passed,
  output logic                         timeout,
  output logic [NUM_CHECKS-1:0]        fail_mask,
  output logic [CYC_W-1:0]             cycle_count
);

  localparam int c_halt_w = $clog2(HALT_CYCLES);

  state_t                r_state;
  state_t                w_state_next;
  logic [CYC_W-1:0]      r_max_cycles;
  logic [CYC_W-1:0]      r_cycle_count;
  logic [DATA_W-1:0]     r_prev_pc;
  logic [c_halt_w-1:0]   r_halt_cnt;
  logic                  r_to_flag;
  logic                  r_passed;
  logic                  r_timeout;
  logic [NUM_CHECKS-1:0] r_fail_mask;
  logic [NUM_CHECKS-1:0] w_mismatch;
  logic [CYC_W:0]        w_cnt_inc;
  logic                  w_arm;
  logic                  w_run;
  logic                  w_pc_same;
  logic                  w_halt;
  logic                  w_timeout;

  assign w_run     = (r_state == ST_RUN);
  assign w_arm     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_pc_same = (pc == r_prev_pc);
  // Counter already holds HALT_CYCLES-2 repeats, so this sample completes the run.
  assign w_halt    = w_run && w_pc_same && (r_halt_cnt == c_halt_w'(HALT_CYCLES - 2));
  assign w_cnt_inc = {1'b0, r_cycle_count} + (CYC_W + 1)'(1);
  assign w_timeout = w_run && (r_max_cycles != '0) && (w_cnt_inc == {1'b0, r_max_cycles});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_halt || w_timeout) w_state_next = ST_COMPARE;
      end
      ST_COMPARE: begin
        busy         = 1'b1;
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_max_cycles  <= '0;
      r_cycle_count <= '0;
      r_prev_pc     <= '0;
      r_halt_cnt    <= '0;
      r_to_flag     <= 1'b0;
      r_passed      <= 1'b0;
      r_timeout     <= 1'b0;
      r_fail_mask   <= '0;
    end else if (w_arm) begin
      r_max_cycles  <= max_cycles;
      r_cycle_count <= '0;
      r_prev_pc     <= pc;
      r_halt_cnt    <= '0;
      r_to_flag     <= 1'b0;
      r_passed      <= 1'b0;
      r_timeout     <= 1'b0;
      r_fail_mask   <= '0;
    end else if (w_run) begin
      if (r_cycle_count != '1) r_cycle_count <= w_cnt_inc[CYC_W-1:0];
      r_prev_pc <= pc;
      if (!w_pc_same) begin
        r_halt_cnt <= '0;
      end else if (r_halt_cnt != c_halt_w'(HALT_CYCLES - 1)) begin
        r_halt_cnt <= r_halt_cnt + c_halt_w'(1);
      end
      // Halt takes priority when both conditions land on the same cycle.
      r_to_flag <= w_timeout && !w_halt;
    end else if (r_state == ST_COMPARE) begin
      r_fail_mask <= w_mismatch;
      r_timeout   <= r_to_flag;
      r_passed    <= !r_to_flag && (w_mismatch == '0);
    end
  end

  for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_channel
    cpu_check_channel #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_arm),
      .cfg_valid (exp_valid[gi]),
      .cfg_addr  (exp_addr[gi*ADDR_W +: ADDR_W]),
      .cfg_data  (exp_data[gi*DATA_W +: DATA_W]),
      .capture   (w_run),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .mismatch  (w_mismatch[gi])
    );
  end

  assign passed      = r_passed;
  assign timeout     = r_timeout;
  assign fail_mask   = r_fail_mask;
  assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_result_checker.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_result_checker                                                       |
// | Drives program traces into the checker and grades it against a trace model|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_cpu_result_checker;

  localparam int NC = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int HC = 4;
  localparam int TL = 128;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [CW-1:0]  max_cycles;
  logic [DW-1:0]  pc;
  logic           rf_we;
  logic [AW-1:0]  rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic [NC-1:0]  exp_valid;
  logic [NC*AW-1:0] exp_addr;
  logic [NC*DW-1:0] exp_data;
  logic           busy, done, passed, timeout;
  logic [NC-1:0]  fail_mask;
  logic [CW-1:0]  cycle_count;

  cpu_result_checker #(
    .NUM_CHECKS(NC), .ADDR_W(AW), .DATA_W(DW), .CYC_W(CW), .HALT_CYCLES(HC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_cycles(max_cycles), .pc(pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data),
    .busy(busy), .done(done), .passed(passed), .timeout(timeout),
    .fail_mask(fail_mask), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Program trace: index 0 is the start cycle, index j the j-th RUN cycle.
  logic [DW-1:0] tr_pc   [TL];
  logic          tr_we   [TL];
  logic [AW-1:0] tr_addr [TL];
  logic [DW-1:0] tr_data [TL];

  logic [NC-1:0] cfg_valid;
  logic [AW-1:0] cfg_addr [NC];
  logic [DW-1:0] cfg_data [NC];
  logic [CW-1:0] cfg_max;

  int            exp_exit;
  logic          exp_to;
  logic [NC-1:0] exp_mask;
  logic          exp_pass;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd2;
      2: return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic gen_program(input int run_len, input logic [DW-1:0] base);
    for (int j = 0; j < TL; j++) begin
      tr_pc[j]   = (j < run_len) ? base + 32'(4 * j) : base + 32'(4 * run_len);
      tr_we[j]   = 1'($urandom_range(0, 1));
      tr_addr[j] = pick_addr();
      tr_data[j] = $urandom;
    end
  endtask

  task automatic clear_writes();
    for (int j = 0; j < TL; j++) tr_we[j] = 1'b0;
  endtask

  task automatic set_write(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
    tr_we[j] = 1'b1; tr_addr[j] = a; tr_data[j] = d;
  endtask

  task automatic set_chan(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_valid[i] = v; cfg_addr[i] = a; cfg_data[i] = d;
  endtask

  // Architectural value of register a after RUN cycles 1..last.
  function automatic logic [DW-1:0] final_reg(input logic [AW-1:0] a, input int last);
    logic [DW-1:0] v;
    v = '0;
    if (a == 5'd0) return v;
    for (int j = 1; j <= last && j < TL; j++)
      if (tr_we[j] && tr_addr[j] == a) v = tr_data[j];
    return v;
  endfunction

  // Halt = first cycle ending a window of HC identical PC samples.
  task automatic model_exit();
    int  halt_j;
    logic same;
    halt_j = 2 * TL;
    for (int j = HC - 1; j < TL; j++) begin
      same = 1'b1;
      for (int m = j - HC + 1; m < j; m++) if (tr_pc[m] != tr_pc[j]) same = 1'b0;
      if (same) begin halt_j = j; break; end
    end
    exp_to   = (cfg_max != 0) && (int'(cfg_max) < halt_j);
    exp_exit = exp_to ? int'(cfg_max) : halt_j;
  endtask

  task automatic model_result();
    exp_mask = '0;
    for (int i = 0; i < NC; i++)
      if (cfg_valid[i] && final_reg(cfg_addr[i], exp_exit) != cfg_data[i]) exp_mask[i] = 1'b1;
    exp_pass = !exp_to && (exp_mask == '0);
  endtask

  task automatic drive_cfg();
    max_cycles = cfg_max;
    exp_valid  = cfg_valid;
    for (int i = 0; i < NC; i++) begin
      exp_addr[i*AW +: AW] = cfg_addr[i];
      exp_data[i*DW +: DW] = cfg_data[i];
    end
  endtask

  task automatic run_program(output int k_done, output logic [23:0] arm_snap);
    @(negedge clk);
    drive_cfg();
    start = 1'b1; pc = tr_pc[0]; rf_we = 1'b0;
    k_done = -1; arm_snap = '1;
    for (int k = 1; k < TL; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) arm_snap = {busy, done, passed, timeout, fail_mask, cycle_count};
      if (done) begin k_done = k; break; end
      pc = tr_pc[k]; rf_we = tr_we[k]; rf_waddr = tr_addr[k]; rf_wdata = tr_data[k];
    end
    rf_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pc = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    max_cycles = '0; exp_valid = '0; exp_addr = '0; exp_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (passed !== 1'b0) begin n_err++; $display("FAIL reset_passed: got %b want 0", passed); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_cmp++; if (fail_mask !== 4'b0) begin n_err++; $display("FAIL reset_mask: got %b want 0000", fail_mask); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
  endtask

  task automatic test_simple();
    int k; logic [23:0] snap;
    gen_program(16, 32'h0); clear_writes();
    set_write(2, 5'd2, 32'd1); set_write(5, 5'd2, 32'd4);
    set_chan(0, 1, 5'd2, 32'd4); set_chan(1, 0, 5'd3, 32'd7);
    set_chan(2, 0, 5'd4, 32'd7); set_chan(3, 0, 5'd5, 32'd7);
    cfg_max = 16'd0;
    run_program(k, snap);
    n_cmp++; if (k !== 21) begin n_err++; $display("FAIL simple_latency: got %0d want 21", k); end
    n_cmp++; if (passed !== 1'b1) begin n_err++; $display("FAIL simple_passed: got %b want 1", passed); end
    n_cmp++; if (fail_mask !== 4'b0000) begin n_err++; $display("FAIL simple_mask: got %b want 0000", fail_mask); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL simple_timeout: got %b want 0", timeout); end
    n_cmp++; if (cycle_count !== 16'd19) begin n_err++; $display("FAIL simple_count: got %0d want 19", cycle_count); end
  endtask

  task automatic test_mismatch();
    int k; logic [23:0] snap;
    gen_program(10, 32'h100); clear_writes();
    set_write(2, 5'd2, 32'd270); set_write(4, 5'd5, 32'd99); set_write(6, 5'd2, 32'd58);
    set_chan(0, 1, 5'd7, 32'd0); set_chan(1, 1, 5'd2, 32'd270);
    set_chan(2, 0, 5'd0, 32'd0); set_chan(3, 0, 5'd5, 32'd1);
    cfg_max = 16'd0;
    run_program(k, snap);
    n_cmp++; if (fail_mask !== 4'b0010) begin n_err++; $display("FAIL mismatch_mask: got %b want 0010", fail_mask); end
    n_cmp++; if (passed !== 1'b0) begin n_err++; $display("FAIL mismatch_passed: got %b want 0", passed); end
    n_cmp++; if (k !== 15) begin n_err++; $display("FAIL mismatch_latency: got %0d want 15", k); end
  endtask

  task automatic test_timeout();
    int k; logic [23:0] snap;
    gen_program(TL, 32'h0);
    set_chan(0, 0, 5'd1, 32'd0); set_chan(1, 0, 5'd1, 32'd0);
    set_chan(2, 0, 5'd1, 32'd0); set_chan(3, 0, 5'd1, 32'd0);
    cfg_max = 16'd50;
    run_program(k, snap);
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b want 1", timeout); end
    n_cmp++; if (passed !== 1'b0) begin n_err++; $display("FAIL timeout_passed: got %b want 0", passed); end
    n_cmp++; if (cycle_count !== 16'd50) begin n_err++; $display("FAIL timeout_count: got %0d want 50", cycle_count); end
    n_cmp++; if (k !== 52) begin n_err++; $display("FAIL timeout_latency: got %0d want 52", k); end
  endtask

  task automatic test_r0_shared();
    int k; logic [23:0] snap;
    gen_program(12, 32'h200); clear_writes();
    set_write(3, 5'd0, 32'h0000_FFFF); set_write(4, 5'd9, 32'h1234); set_write(8, 5'd9, 32'hABCD);
    set_chan(0, 1, 5'd0, 32'd0); set_chan(1, 1, 5'd9, 32'hABCD);
    set_chan(2, 1, 5'd0, 32'd0); set_chan(3, 1, 5'd9, 32'hABCD);
    cfg_max = 16'd0;
    run_program(k, snap);
    n_cmp++; if (fail_mask !== 4'b0000) begin n_err++; $display("FAIL r0_shared_mask: got %b want 0000", fail_mask); end
    n_cmp++; if (passed !== 1'b1) begin n_err++; $display("FAIL r0_shared_passed: got %b want 1", passed); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL r0_shared_done: got %b want 1", done); end
  endtask

  task automatic test_tie_rearm();
    int k; logic [23:0] snap;
    gen_program(17, 32'h0); clear_writes();
    set_write(3, 5'd2, 32'd4);
    set_chan(0, 1, 5'd2, 32'd4); set_chan(1, 0, 5'd1, 32'd0);
    set_chan(2, 0, 5'd1, 32'd0); set_chan(3, 0, 5'd1, 32'd0);
    cfg_max = 16'd20;
    run_program(k, snap);
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL tie_timeout: got %b want 0", timeout); end
    n_cmp++; if (passed !== 1'b1) begin n_err++; $display("FAIL tie_passed: got %b want 1", passed); end
    n_cmp++; if (cycle_count !== 16'd20) begin n_err++; $display("FAIL tie_count: got %0d want 20", cycle_count); end
    n_cmp++; if (k !== 22) begin n_err++; $display("FAIL tie_latency: got %0d want 22", k); end
    // Second run re-armed from DONE; channel 0 now expects a cleared shadow.
    gen_program(TL, 32'h0); clear_writes();
    set_chan(0, 1, 5'd2, 32'd0);
    cfg_max = 16'd30;
    run_program(k, snap);
    n_cmp++; if (snap !== 24'h80_0000) begin n_err++; $display("FAIL rearm_clear: got %h want 800000", snap); end
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL rearm_timeout: got %b want 1", timeout); end
    n_cmp++; if (passed !== 1'b0) begin n_err++; $display("FAIL rearm_passed: got %b want 0", passed); end
    n_cmp++; if (fail_mask !== 4'b0000) begin n_err++; $display("FAIL rearm_mask: got %b want 0000", fail_mask); end
    n_cmp++; if (cycle_count !== 16'd30) begin n_err++; $display("FAIL rearm_count: got %0d want 30", cycle_count); end
    n_cmp++; if (k !== 32) begin n_err++; $display("FAIL rearm_latency: got %0d want 32", k); end
  endtask

  task automatic test_reset_mid_run();
    int k; logic [23:0] snap;
    gen_program(40, 32'h300);
    set_chan(0, 1, 5'd2, 32'd1); set_chan(1, 1, 5'd9, 32'd2);
    set_chan(2, 1, 5'd3, 32'd3); set_chan(3, 1, 5'd4, 32'd4);
    cfg_max = 16'd0;
    @(negedge clk);
    drive_cfg(); start = 1'b1; pc = tr_pc[0];
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      start = 1'b0; pc = tr_pc[j]; rf_we = tr_we[j]; rf_waddr = tr_addr[j]; rf_wdata = tr_data[j];
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst_n = 1'b0; rf_we = 1'b0;
    @(negedge clk);
    snap = {busy, done, passed, timeout, fail_mask, cycle_count};
    n_cmp++; if (snap !== 24'h0) begin n_err++; $display("FAIL midrst_outputs: got %h want 000000", snap); end
    rst_n = 1'b1;
    gen_program(8, 32'h400); clear_writes();
    set_write(2, 5'd9, 32'h55);
    set_chan(0, 1, 5'd9, 32'h55); set_chan(1, 1, 5'd2, 32'd0);
    set_chan(2, 0, 5'd1, 32'd1); set_chan(3, 0, 5'd1, 32'd1);
    model_exit(); model_result();
    run_program(k, snap);
    n_cmp++; if (k !== exp_exit + 2) begin n_err++; $display("FAIL midrst_latency: got %0d want %0d", k, exp_exit + 2); end
    n_cmp++; if (passed !== exp_pass) begin n_err++; $display("FAIL midrst_passed: got %b want %b", passed, exp_pass); end
    n_cmp++; if (fail_mask !== exp_mask) begin n_err++; $display("FAIL midrst_mask: got %b want %b", fail_mask, exp_mask); end
  endtask

  task automatic test_random();
    int k; logic [23:0] snap; logic [DW-1:0] v;
    for (int it = 0; it < 24; it++) begin
      gen_program($urandom_range(2, 60), 32'($urandom_range(0, 255) * 4));
      cfg_max   = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 70));
      cfg_valid = 4'($urandom);
      for (int i = 0; i < NC; i++) cfg_addr[i] = pick_addr();
      model_exit();
      for (int i = 0; i < NC; i++) begin
        v = final_reg(cfg_addr[i], exp_exit);
        cfg_data[i] = ($urandom_range(0, 1) == 1) ? v : v ^ 32'($urandom_range(1, 255));
      end
      model_result();
      run_program(k, snap);
      n_cmp++; if (k !== exp_exit + 2) begin n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", it, k, exp_exit + 2); end
      n_cmp++; if (timeout !== exp_to) begin n_err++; $display("FAIL rand%0d_timeout: got %b want %b", it, timeout, exp_to); end
      n_cmp++; if (fail_mask !== exp_mask) begin n_err++; $display("FAIL rand%0d_mask: got %b want %b", it, fail_mask, exp_mask); end
      n_cmp++; if (passed !== exp_pass) begin n_err++; $display("FAIL rand%0d_passed: got %b want %b", it, passed, exp_pass); end
      n_cmp++; if (cycle_count !== 16'(exp_exit)) begin n_err++; $display("FAIL rand%0d_count: got %0d want %0d", it, cycle_count, exp_exit); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand%0d_busy: got %b want 0", it, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_mismatch();
    test_timeout();
    test_r0_shared();
    test_tie_rearm();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
